// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared FSM state encoding and default widths for the
//               fetch/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_TIMEOUT = 16;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 3'd0;
    localparam arb_state_t ST_DATA   = 3'd1;
    localparam arb_state_t ST_FETCH  = 3'd2;
    localparam arb_state_t ST_DONE_D = 3'd3;
    localparam arb_state_t ST_DONE_F = 3'd4;

    // True while a memory transaction is outstanding
    function automatic logic is_busy(input arb_state_t s);
        return (s == ST_DATA) || (s == ST_FETCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_watchdog
// Description : Counts cycles an outstanding memory transaction has waited
//               for its ack and flags expiry on the TIMEOUT-th such cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic i_clear,    // entering a busy state
    input  logic i_count,    // busy and no ack this cycle
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear on transaction start, otherwise count waiting cycles
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_count) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry fires during the cycle whose increment would reach TIMEOUT
    assign o_expired = i_count && (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between an instruction fetch
//               port and a data port. Data wins simultaneous requests;
//               after a data completion fetch is preferred and vice versa.
//               Optional feature macro: MEM_ARB_TIMEOUT_EN (ack watchdog,
//               sticky arb_err).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              arb_err
);

    arb_state_t        state_q,    state_d;
    logic              mem_req_q,  mem_req_d;
    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic w_dm_req;
    logic w_go_data;
    logic w_go_fetch;
    logic w_expire;

    assign w_dm_req = dm_read | dm_write;

    // Next-state, transaction launch and read-data capture
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        w_go_data   = 1'b0;
        w_go_fetch  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_dm_req)    w_go_data  = 1'b1;
                else if (if_req) w_go_fetch = 1'b1;
            end
            ST_DATA: begin
                if (mem_ack) begin
                    state_d = ST_DONE_D;
                    // A store leaves the previous load result in place
                    if (!mem_we_q) dm_rdata_d = mem_rdata;
                end else if (w_expire) begin
                    state_d    = ST_DONE_D;
                    dm_rdata_d = '0;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d    = ST_DONE_F;
                    if_rdata_d = mem_rdata;
                end else if (w_expire) begin
                    state_d    = ST_DONE_F;
                    if_rdata_d = '0;
                end
            end
            ST_DONE_D: begin
                if (if_req)        w_go_fetch = 1'b1;
                else if (w_dm_req) w_go_data  = 1'b1;
                else               state_d    = ST_IDLE;
            end
            ST_DONE_F: begin
                if (w_dm_req)    w_go_data  = 1'b1;
                else if (if_req) w_go_fetch = 1'b1;
                else             state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Latch the request so the memory sees stable signals until ack
        if (w_go_data) begin
            state_d     = ST_DATA;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_we_d    = dm_write;
        end else if (w_go_fetch) begin
            state_d     = ST_FETCH;
            mem_addr_d  = if_addr;
            mem_we_d    = 1'b0;
        end

        mem_req_d = is_busy(state_d);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic arb_err_q, arb_err_d;
    logic w_wd_clear;
    logic w_wd_count;

    assign w_wd_clear = is_busy(state_d) && (state_d != state_q);
    assign w_wd_count = is_busy(state_q) && !mem_ack;

    mem_arb_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wd_clear),
        .i_count   (w_wd_count),
        .o_expired (w_expire)
    );

    // Error flag stays set once any transaction has timed out
    always_comb begin
        arb_err_d = arb_err_q | w_expire;
    end

    // Sticky error register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_err_q <= 1'b0;
        end else begin
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign w_expire       = 1'b0;
    assign arb_err        = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // Stalls release only in the completion state of the matching requester
    assign dm_stall = w_dm_req && (state_q != ST_DONE_D);
    assign if_stall = if_req   && (state_q != ST_DONE_F);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        arb_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .arb_err   (arb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst_mem_req",   {31'd0, mem_req},  32'd0);
        check("rst_mem_we",    {31'd0, mem_we},   32'd0);
        check("rst_mem_addr",  mem_addr,          32'd0);
        check("rst_mem_wdata", mem_wdata,         32'd0);
        check("rst_if_rdata",  if_rdata,          32'd0);
        check("rst_dm_rdata",  dm_rdata,          32'd0);
        check("rst_arb_err",   {31'd0, arb_err},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ---------------- fetch, zero-wait memory ----------------
        if_req  = 1'b1;
        if_addr = 32'h40;
        #1;
        check("f_stall_req",   {31'd0, if_stall}, 32'd1);
        check("f_mem_req_idle",{31'd0, mem_req},  32'd0);
        tick();
        check("f_mem_req",     {31'd0, mem_req},  32'd1);
        check("f_mem_addr",    mem_addr,          32'h40);
        check("f_mem_we",      {31'd0, mem_we},   32'd0);
        check("f_stall_busy",  {31'd0, if_stall}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C010004;
        tick();
        check("f_stall_done",  {31'd0, if_stall}, 32'd0);
        check("f_if_rdata",    if_rdata,          32'h8C010004);
        check("f_mem_req_done",{31'd0, mem_req},  32'd0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();

        // ---------------- simultaneous data read + fetch ----------------
        dm_read = 1'b1;
        dm_addr = 32'h100;
        if_req  = 1'b1;
        if_addr = 32'h44;
        #1;
        check("s_dm_stall_req", {31'd0, dm_stall}, 32'd1);
        tick();
        check("s_data_first",   mem_addr,          32'h100);
        check("s_data_we",      {31'd0, mem_we},   32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11112222;
        tick();
        check("s_dm_stall_done",{31'd0, dm_stall}, 32'd0);
        check("s_dm_rdata",     dm_rdata,          32'h11112222);
        check("s_if_stall_dd",  {31'd0, if_stall}, 32'd1);
        mem_ack = 1'b0;
        dm_read = 1'b0;
        tick();
        check("s_fetch_req",    {31'd0, mem_req},  32'd1);
        check("s_fetch_addr",   mem_addr,          32'h44);
        mem_ack   = 1'b1;
        mem_rdata = 32'h33334444;
        tick();
        check("s_if_rdata",     if_rdata,          32'h33334444);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();

        // ---------------- store, one wait cycle ----------------
        dm_write = 1'b1;
        dm_addr  = 32'h200;
        dm_wdata = 32'hDEADBEEF;
        tick();
        check("w_mem_we",     {31'd0, mem_we},   32'd1);
        check("w_mem_wdata",  mem_wdata,         32'hDEADBEEF);
        dm_wdata = 32'h0;
        dm_addr  = 32'h204;
        tick();
        check("w_wdata_hold", mem_wdata,         32'hDEADBEEF);
        check("w_addr_hold",  mem_addr,          32'h200);
        check("w_stall_wait", {31'd0, dm_stall}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        check("w_dm_rdata",   dm_rdata,          32'h11112222);
        check("w_stall_done", {31'd0, dm_stall}, 32'd0);
        mem_ack  = 1'b0;
        dm_write = 1'b0;
        tick();

        // ---------------- stray ack in IDLE ----------------
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        check("x_mem_req",  {31'd0, mem_req}, 32'd0);
        check("x_if_rdata", if_rdata,         32'h33334444);
        check("x_dm_rdata", dm_rdata,         32'h11112222);
        mem_ack = 1'b0;

        // ---------------- read and write together act as a store ----------------
        dm_read  = 1'b1;
        dm_write = 1'b1;
        dm_addr  = 32'h210;
        dm_wdata = 32'hCAFEF00D;
        tick();
        check("rw_mem_we",  {31'd0, mem_we}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        tick();
        check("rw_dm_rdata", dm_rdata,       32'h11112222);
        mem_ack  = 1'b0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        tick();

        // ---------------- fetch request dropped mid-transaction ----------------
        if_req  = 1'b1;
        if_addr = 32'h60;
        tick();
        if_req = 1'b0;
        #1;
        check("d_if_stall",  {31'd0, if_stall}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hABCD0123;
        tick();
        check("d_if_rdata",  if_rdata,          32'hABCD0123);
        mem_ack = 1'b0;
        tick();

        // ---------------- reset during fetch ----------------
        if_req  = 1'b1;
        if_addr = 32'h80;
        tick();
        check("r_mem_req_pre", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("r_mem_req_async", {31'd0, mem_req}, 32'd0);
        check("r_if_rdata_rst",  if_rdata,         32'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h99999999;
        tick();
        check("r_late_ack", if_rdata, 32'd0);
        mem_ack = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'hC0;
        #1;
        check("r_idle_first", {31'd0, mem_req}, 32'd0);
        tick();
        check("r_new_addr",   mem_addr,         32'hC0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        check("r_new_rdata",  if_rdata,         32'h12345678);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();

        // ---------------- no ack for an extended period ----------------
        dm_read = 1'b1;
        dm_addr = 32'h300;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("t_req_cycle16", {31'd0, mem_req}, 32'd1);
        check("t_err_cycle16", {31'd0, arb_err}, 32'd0);
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        check("t_arb_err",   {31'd0, arb_err},  32'd1);
        check("t_dm_rdata",  dm_rdata,          32'd0);
        check("t_dm_stall",  {31'd0, dm_stall}, 32'd0);
        check("t_mem_req",   {31'd0, mem_req},  32'd0);
        dm_read = 1'b0;
        tick();
        tick();
        check("t_err_sticky",{31'd0, arb_err},  32'd1);
`else
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        check("n_mem_req",   {31'd0, mem_req},  32'd1);
        check("n_dm_stall",  {31'd0, dm_stall}, 32'd1);
        check("n_arb_err",   {31'd0, arb_err},  32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        check("n_dm_rdata",  dm_rdata,          32'h0BADF00D);
        check("n_stall_rel", {31'd0, dm_stall}, 32'd0);
        mem_ack = 1'b0;
        dm_read = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL provide parameter DATA_W, default 32, data width.
REQ-003 The block SHALL provide parameter TIMEOUT, default 16, cycles without ack before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-004 The block SHALL provide these ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- if_req  input  1  fetch request
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched instruction
- if_stall  output  1  freeze PC/IF_ID
- dm_read  input  1  data load
- dm_write  input  1  data store
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_rdata  output  DATA_W  load data
- dm_stall  output  1  freeze pipeline at MEM
- mem_req  output  1  memory request
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- mem_ack  input  1  memory completion, one-cycle pulse
- arb_err  output  1  sticky timeout flag

Function
REQ-005 The block SHALL share one single-port memory between the fetch and data requesters using FSM states IDLE, DATA, FETCH, DONE_D and DONE_F.
REQ-006 IDLE: if dm_read or dm_write then DATA, else if if_req then FETCH, else stay; simultaneous requests SHALL go to DATA.
REQ-007 On leaving IDLE the block SHALL register the address, write data and we (we = dm_write), and drive them on mem_addr, mem_wdata and mem_we, stable until ack.
REQ-008 mem_req SHALL be registered, high in every cycle of DATA and FETCH, and low in all other states.
REQ-009 DATA or FETCH SHALL move to DONE_D or DONE_F on the cycle mem_ack=1, capturing mem_rdata into dm_rdata or if_rdata; on a store, dm_rdata SHALL hold its previous value.
REQ-010 DONE_D SHALL go next to FETCH if if_req, else DATA if a data request, else IDLE; DONE_F SHALL give data priority, then fetch, then IDLE.
REQ-011 dm_stall SHALL equal (dm_read|dm_write) & (state!=DONE_D); if_stall SHALL equal if_req & (state!=DONE_F); both are combinational.
REQ-012 The minimum latency from request to stall release SHALL be 3 cycles (request, mem_req, ack with zero-wait memory, result in DONE).
REQ-013 If if_req drops during FETCH, the transaction SHALL complete, if_rdata SHALL update and no stall results.
REQ-014 A mem_ack arriving in IDLE or DONE_x SHALL be ignored.
REQ-015 dm_read and dm_write both high SHALL be treated as a store.

Reset
REQ-016 rst low SHALL asynchronously force state IDLE; mem_req, mem_we, arb_err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
REQ-017 Reset mid-transaction SHALL abandon the transaction with no output update, and the first request after release SHALL start from IDLE.

Configuration
REQ-018 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to DATA or FETCH and increment each cycle without ack.
REQ-019 With MEM_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL go to DONE_x with rdata 0, drop mem_req, and set arb_err until reset.
REQ-020 Without MEM_ARB_TIMEOUT_EN, the block SHALL wait indefinitely for mem_ack and arb_err SHALL be constant 0.

Structure
REQ-021 The shared package SHALL hold the FSM state typedef arb_state_t and default ADDR_W, DATA_W and TIMEOUT constants.
REQ-022 The timeout counter SHALL be sub-module mem_arb_watchdog, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-023 The bench SHALL cover each scenario below:
- if_req=1, if_addr=0x40, memory acks 1 cycle after mem_req with 0x8C010004 -> if_rdata=0x8C010004, if_stall low in DONE_F, 3 cycles total.
- dm_read and if_req in the same cycle (dm_addr=0x100) -> DATA served first, dm_stall released in DONE_D, then FETCH entered with no IDLE cycle.
- dm_write=1, dm_addr=0x200, dm_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF stable until ack; dm_rdata unchanged.
- rst asserted during FETCH before ack -> mem_req=0 immediately; a late ack causes no if_rdata update.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=16, no ack -> after 16 cycles arb_err=1, dm_rdata=0, dm_stall released, arb_err stays 1.
- Stray mem_ack in IDLE -> no state change, no output change.
